// File: rtl/control_fsm_pkg.sv
// Shared state encodings, opcode constants and datapath mux codes for control_fsm.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F    = 4'd1,
    S_D    = 4'd2,
    S_OP1  = 4'd3,
    S_OP2  = 4'd4,
    S_WC   = 4'd5,
    S_GA   = 4'd6,
    S_WB   = 4'd7,
    S_OA   = 4'd8,
    S_JP   = 4'd9,
    S_COU  = 4'd10,
    S_HALT = 4'd11,
    S_ERR  = 4'd12
  } state_t;

  localparam logic [2:0] OPC_SUM = 3'd0;
  localparam logic [2:0] OPC_RES = 3'd1;
  localparam logic [2:0] OPC_MOV = 3'd2;
  localparam logic [2:0] OPC_OUT = 3'd3;
  localparam logic [2:0] OPC_AND = 3'd4;
  localparam logic [2:0] OPC_OR  = 3'd5;
  localparam logic [2:0] OPC_JMP = 3'd6;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_OP1  = 2'b01;
  localparam logic [1:0] SEL_OP2  = 2'b10;
  localparam logic [1:0] SEL_WR   = 2'b11;

endpackage

// File: rtl/control_fsm.sv
// Moore control FSM sequencing fetch/decode/operand/writeback for a small CPU.
// Optional jump support is enabled by defining CONTROL_FSM_JMP_EN.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int                PC_W     = 4,
  parameter int                OP_W     = 3,
  parameter logic [PC_W-1:0]   END_ADDR = {PC_W{1'b1}},
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   operacion,
  input  logic [PC_W-1:0]   pc,
  input  logic              mem_rdy,
  output logic              mem_req,
  output logic              enmem,
  output logic              enir,
  output logic              enrop1,
  output logic              enrop2,
  output logic              enrio,
  output logic              enpc,
  output logic              ldpc,
  output logic [OP_W-1:0]   seloper,
  output logic [1:0]        selmux,
  output logic              halted,
  output logic              err,
  output logic [3:0]        state,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_t cur;
  state_t nxt;
  logic   count_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (count_en) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end else begin
      instr_cnt <= instr_cnt;
    end
  end

`ifdef CONTROL_FSM_JMP_EN
  assign count_en = (cur == S_COU) || (cur == S_JP);
`else
  assign count_en = (cur == S_COU);
`endif

  assign state = cur;

  // Next-state and Moore output decode; only the enables are qualified by mem_rdy
  always_comb begin
    nxt     = cur;
    mem_req = 1'b0;
    enmem   = 1'b0;
    enir    = 1'b0;
    enrop1  = 1'b0;
    enrop2  = 1'b0;
    enrio   = 1'b0;
    enpc    = 1'b0;
    ldpc    = 1'b0;
    seloper = '0;
    selmux  = SEL_NONE;
    halted  = 1'b0;
    err     = 1'b0;
    case (cur)
      S_IDLE: begin
        if (start) nxt = S_F;
        else       nxt = S_IDLE;
      end
      S_F: begin
        mem_req = 1'b1;
        enir    = mem_rdy;
        if (mem_rdy) nxt = S_D;
        else         nxt = S_F;
      end
      S_D: begin
        case (operacion)
          OP_W'(OPC_SUM), OP_W'(OPC_RES),
          OP_W'(OPC_AND), OP_W'(OPC_OR):  nxt = S_OP1;
          OP_W'(OPC_MOV):                 nxt = S_GA;
          OP_W'(OPC_OUT):                 nxt = S_OA;
`ifdef CONTROL_FSM_JMP_EN
          OP_W'(OPC_JMP):                 nxt = S_JP;
`endif
          default:                        nxt = S_ERR;
        endcase
      end
      S_OP1: begin
        mem_req = 1'b1;
        selmux  = SEL_OP1;
        enrop1  = mem_rdy;
        if (mem_rdy) nxt = S_OP2;
        else         nxt = S_OP1;
      end
      S_OP2: begin
        mem_req = 1'b1;
        selmux  = SEL_OP2;
        seloper = operacion;
        enrop2  = mem_rdy;
        if (mem_rdy) nxt = S_WC;
        else         nxt = S_OP2;
      end
      S_WC: begin
        mem_req = 1'b1;
        selmux  = SEL_WR;
        seloper = operacion;
        enmem   = mem_rdy;
        if (mem_rdy) nxt = S_COU;
        else         nxt = S_WC;
      end
      S_GA: begin
        mem_req = 1'b1;
        selmux  = SEL_OP1;
        enrop1  = mem_rdy;
        if (mem_rdy) nxt = S_WB;
        else         nxt = S_GA;
      end
      S_WB: begin
        mem_req = 1'b1;
        selmux  = SEL_OP2;
        seloper = operacion;
        enmem   = mem_rdy;
        if (mem_rdy) nxt = S_COU;
        else         nxt = S_WB;
      end
      S_OA: begin
        selmux = SEL_OP1;
        enrio  = 1'b1;
        nxt    = S_COU;
      end
`ifdef CONTROL_FSM_JMP_EN
      S_JP: begin
        ldpc = 1'b1;
        nxt  = S_F;
      end
`endif
      S_COU: begin
        enpc = 1'b1;
        if (pc == END_ADDR) nxt = S_HALT;
        else                nxt = S_F;
      end
      S_HALT: begin
        halted = 1'b1;
        nxt    = S_HALT;
      end
      S_ERR: begin
        err = 1'b1;
        nxt = S_ERR;
      end
      // Unused encodings (and JP when jumps are disabled) trap into ERR
      default: nxt = S_ERR;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm (CNT_W=2 so the counter wrap is reachable).
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] operacion;
  logic [3:0] pc;
  logic       mem_rdy;
  logic       mem_req, enmem, enir, enrop1, enrop2, enrio, enpc, ldpc;
  logic [2:0] seloper;
  logic [1:0] selmux;
  logic       halted, err;
  logic [3:0] state;
  logic [1:0] instr_cnt;

  int checks = 0;
  int errors = 0;

  control_fsm #(.PC_W(4), .OP_W(3), .END_ADDR(4'd15), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operacion(operacion), .pc(pc),
    .mem_rdy(mem_rdy), .mem_req(mem_req), .enmem(enmem), .enir(enir),
    .enrop1(enrop1), .enrop2(enrop2), .enrio(enrio), .enpc(enpc), .ldpc(ldpc),
    .seloper(seloper), .selmux(selmux), .halted(halted), .err(err),
    .state(state), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample point is 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (state !== target && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {28'd0, state}, {28'd0, target});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, mem_req, enmem, enir, enrop1, enrop2, enrio, enpc, ldpc,
            halted, err, seloper, selmux, state, instr_cnt};
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; operacion = 3'd0; pc = 4'd0; mem_rdy = 1'b1;
    #2;
    chk("reset_outputs", all_outs(), 32'd0);
    tick();
    rst_n = 1'b1;

    // SUM with memory always ready
    operacion = OPC_SUM;
    pulse_start();
    chk("sum_f_state", {28'd0, state}, {28'd0, S_F});
    chk("sum_f_enir", {31'd0, enir}, 32'd1);
    tick(); chk("sum_d_state", {28'd0, state}, {28'd0, S_D});
    chk("sum_d_memreq", {31'd0, mem_req}, 32'd0);
    tick(); chk("sum_op1", {27'd0, state, enrop1}, {27'd0, S_OP1, 1'b1});
    chk("sum_op1_sel", {30'd0, selmux}, 32'd1);
    tick(); chk("sum_op2", {25'd0, state, enrop2, selmux}, {25'd0, S_OP2, 1'b1, 2'b10});
    tick(); chk("sum_wc", {22'd0, state, enmem, selmux, seloper}, {22'd0, S_WC, 1'b1, 2'b11, 3'd0});
    tick(); chk("sum_cou", {27'd0, state, enpc}, {27'd0, S_COU, 1'b1});
    tick(); chk("sum_back_f", {28'd0, state}, {28'd0, S_F});
    chk("sum_cnt", {30'd0, instr_cnt}, 32'd1);

    // MOV with GA stalled three cycles
    operacion = OPC_MOV;
    tick(); chk("mov_d", {28'd0, state}, {28'd0, S_D});
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_rdy = 1'b0;
      #1;
      chk("mov_ga_wait", {27'd0, state, enrop1}, {27'd0, S_GA, 1'b0});
      tick();
    end
    mem_rdy = 1'b1;
    #1;
    chk("mov_ga_last", {27'd0, state, enrop1}, {27'd0, S_GA, 1'b1});
    tick(); chk("mov_wb", {22'd0, state, enmem, selmux, seloper}, {22'd0, S_WB, 1'b1, 2'b10, 3'd2});
    tick(); chk("mov_cou", {28'd0, state}, {28'd0, S_COU});
    tick(); chk("mov_cnt", {30'd0, instr_cnt}, 32'd2);

    // RES, AND, OR: counter wraps 3 -> 0 -> 1; check seloper in OP2 for RES
    operacion = OPC_RES;
    wait_state(S_OP2, "res_op2");
    chk("res_seloper", {29'd0, seloper}, 32'd1);
    wait_state(S_F, "res_done");
    chk("res_cnt", {30'd0, instr_cnt}, 32'd3);
    operacion = OPC_AND;
    tick(); wait_state(S_F, "and_done");
    chk("and_cnt_wrap", {30'd0, instr_cnt}, 32'd0);
    operacion = OPC_OR;
    tick(); wait_state(S_F, "or_done");
    chk("or_cnt_after_wrap", {30'd0, instr_cnt}, 32'd1);

    // OUT
    operacion = OPC_OUT;
    tick(); tick();
    chk("out_oa", {25'd0, state, enrio, selmux}, {25'd0, S_OA, 1'b1, 2'b01});
    tick(); tick(); chk("out_cnt", {30'd0, instr_cnt}, 32'd2);

    // Last instruction at END_ADDR halts; start is then ignored
    operacion = OPC_SUM;
    pc = 4'd15;
    wait_state(S_COU, "halt_cou");
    tick(); chk("halt_state", {27'd0, state, halted}, {27'd0, S_HALT, 1'b1});
    chk("halt_cnt", {30'd0, instr_cnt}, 32'd3);
    pulse_start();
    tick(); chk("halt_sticky", {27'd0, state, halted}, {27'd0, S_HALT, 1'b1});
    pc = 4'd0;

    // Illegal opcode 7
    do_reset();
    chk("rst_after_halt", all_outs(), 32'd0);
    operacion = 3'd7;
    pulse_start();
    tick(); tick();
    chk("op7_err", {27'd0, state, err}, {27'd0, S_ERR, 1'b1});
    pulse_start();
    tick(); chk("err_sticky", {27'd0, state, err}, {27'd0, S_ERR, 1'b1});

    // Opcode 6: jump when enabled, otherwise error
    do_reset();
    operacion = OPC_JMP;
    pulse_start();
    tick(); tick();
`ifdef CONTROL_FSM_JMP_EN
    chk("jmp_jp", {27'd0, state, ldpc}, {27'd0, S_JP, 1'b1});
    tick(); chk("jmp_f", {27'd0, state, ldpc}, {27'd0, S_F, 1'b0});
    chk("jmp_cnt", {30'd0, instr_cnt}, 32'd1);
`else
    chk("op6_err", {26'd0, state, err, ldpc}, {26'd0, S_ERR, 1'b1, 1'b0});
`endif

    // Asynchronous reset in the middle of an OP2 handshake
    do_reset();
    operacion = OPC_AND;
    pulse_start();
    tick(); tick(); tick();
    mem_rdy = 1'b0;
    #1;
    chk("mid_op2", {27'd0, state, mem_req}, {27'd0, S_OP2, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", all_outs(), 32'd0);
    tick();
    mem_rdy = 1'b1;
    rst_n = 1'b1;
    pulse_start();
    chk("start_after_reset", {28'd0, state}, {28'd0, S_F});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter PC_W, default 4, program-counter width.
REQ-002 Parameter OP_W, default 3, opcode width; shall be at least 3.
REQ-003 Parameter END_ADDR, default {PC_W{1'b1}}, PC value that ends the program.
REQ-004 Parameter CNT_W, default 8, retired-instruction counter width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to leave IDLE.
REQ-008 operacion  in  OP_W  opcode from the instruction register.
REQ-009 pc  in  PC_W  current program counter.
REQ-010 mem_rdy  in  1  memory completes the current access this cycle.
REQ-011 mem_req  out  1  memory access pending.
REQ-012 enmem, enir, enrop1, enrop2, enrio, enpc, ldpc  out  1 each  register and memory write enables; ldpc loads the jump target.
REQ-013 seloper  out  OP_W  ALU operation select.
REQ-014 selmux  out  2  datapath mux select.
REQ-015 halted, err  out  1 each  status flags.
REQ-016 state  out  4  current state encoding, for debug.
REQ-017 instr_cnt  out  CNT_W  count of retired instructions.

Function
REQ-018 The block shall be a Moore FSM; every output except the mem_rdy-qualified enables shall decode from the state register only.
REQ-019 States shall be IDLE, F, D, OP1, OP2, WC, GA, WB, OA, JP, COU, HALT, ERR.
REQ-020 Transitions:
- IDLE->F on start.
- F->D.
- D->OP1 for SUM 0, RES 1, AND 4, OR 5.
- D->GA for MOV 2.
- D->OA for OUT 3.
- D->JP for JMP 6 (REQ-030).
- D->ERR for any other opcode.
- OP1->OP2->WC->COU.
- GA->WB->COU.
- OA->COU.
- JP->F.
REQ-021 Memory states are F, OP1, OP2, WC, GA and WB; in these, mem_req=1 and the state shall hold until mem_rdy=1, advancing on the edge where mem_rdy=1.
REQ-022 enir (F), enrop1 (OP1, GA), enrop2 (OP2) and enmem (WC, WB) shall assert only when in that state and mem_rdy=1.
REQ-023 selmux: OP1, GA and OA = 01; OP2 and WB = 10; WC = 11; all other states 00.
REQ-024 seloper = operacion in OP2, WC and WB, else 0.
REQ-025 In OA, enrio=1. In COU, enpc=1. In JP, ldpc=1.
REQ-026 COU->HALT if pc==END_ADDR, else COU->F; instr_cnt shall increment in COU (JP also increments when present) and wrap modulo 2^CNT_W.
REQ-027 HALT (halted=1) and ERR (err=1) shall be sticky until reset; start is ignored there and in all non-IDLE states.
REQ-028 The next-state logic shall include a default branch to ERR, so no unreachable encoding can lock the FSM.

Reset
REQ-029 rst_n=0 shall immediately force IDLE, instr_cnt=0 and all outputs to 0, including mid-handshake; after release, the first start is accepted on the next edge.

Configuration
REQ-030 Macro CONTROL_FSM_JMP_EN: when defined, opcode 6 selects JP. When undefined, opcode 6 goes to ERR and ldpc is tied to 0.

Structure
REQ-031 State encodings, opcode constants and the selmux codes shall live in shared package control_fsm_pkg.
REQ-032 The block shall be a single module with no sub-modules.

Verification
REQ-033 Reset, start, SUM, mem_rdy=1 always -> state sequence F,D,OP1,OP2,WC,COU,F; instr_cnt=1; seloper=0 in WC.
REQ-034 MOV with mem_rdy low for 3 cycles in GA -> GA held 4 cycles, enrop1 high only in the last; then WB and COU follow.
REQ-035 pc=END_ADDR=15 in COU -> HALT, halted=1; a later start pulse leaves it in HALT.
REQ-036 Opcode 7 -> ERR, err=1; rst_n low mid-OP2 -> IDLE with all outputs 0 asynchronously.
REQ-037 Opcode 6 with macro -> JP, ldpc=1 for one cycle, then F. Opcode 6 without macro -> ERR.
REQ-038 CNT_W=2, five instructions -> instr_cnt reaches 1 after wrap.
